// File: rtl/lab3_sub_pkg.sv
// Shared types and constants for the nibble-serial borrow-lookahead subtractor.
package lab3_sub_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/lab3_serial_bls_sub_if.sv
// Request/result bundle for lab3_serial_bls_sub.
// Carries ovf only when SUB_OVERFLOW_EN is defined.
interface lab3_serial_bls_sub_if #(parameter int NIBBLES = 4);
    import lab3_sub_pkg::*;

    localparam int W = NIB_W * NIBBLES;

    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [W-1:0] d;
    logic         bout;
`ifdef SUB_OVERFLOW_EN
    logic         ovf;
`endif

    modport master (
`ifdef SUB_OVERFLOW_EN
        input  ovf,
`endif
        output start, a, b, bin,
        input  busy, done, d, bout
    );

    modport slave (
`ifdef SUB_OVERFLOW_EN
        output ovf,
`endif
        input  start, a, b, bin,
        output busy, done, d, bout
    );

endinterface

// File: rtl/bls4_slice.sv
// Combinational 4-bit borrow-lookahead subtractor slice: {bo, d4} = a4 - b4 - bi.
module bls4_slice (
    input  logic [3:0] a4,
    input  logic [3:0] b4,
    input  logic       bi,
    output logic [3:0] d4,
    output logic       bo
);

    logic [3:0] g;   // bit generates a borrow on its own (a=0, b=1)
    logic [3:0] p;   // bit passes an incoming borrow through (a == b)
    logic [4:0] c;   // borrow into each bit, c[4] is the slice borrow-out

    // Generate/propagate terms and flattened lookahead borrows
    always_comb begin
        g    = ~a4 & b4;
        p    = ~(a4 ^ b4);
        c[0] = bi;
        c[1] = g[0] | (p[0] & bi);
        c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & bi);
        c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & bi);
        c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
             | (p[3] & p[2] & p[1] & p[0] & bi);
        d4   = a4 ^ b4 ^ c[3:0];
        bo   = c[4];
    end

endmodule

// File: rtl/lab3_serial_bls_sub.sv
// Nibble-serial wide subtractor D = A - B - bin, one bls4_slice pass per cycle,
// LSB nibble first, borrow carried between cycles in br.
// Optional signed-overflow flag under SUB_OVERFLOW_EN.
module lab3_serial_bls_sub
    import lab3_sub_pkg::*;
#(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    lab3_serial_bls_sub_if.slave bus
);

    localparam int              W    = NIB_W * NIBBLES;
    localparam int              IW   = $clog2(NIBBLES);
    localparam logic [IW-1:0]   LAST = IW'(NIBBLES - 1);

    state_e        state;
    logic [W-1:0]  a_r;
    logic [W-1:0]  b_r;
    logic [W-1:0]  d_r;
    logic [IW-1:0] idx;
    logic          br;
    logic          busy_r;
    logic          done_r;
    logic          bout_r;
`ifdef SUB_OVERFLOW_EN
    logic          ovf_r;
`endif

    logic [NIB_W-1:0] diff4;
    logic             br_next;

    bls4_slice u_slice (
        .a4 (a_r[idx*NIB_W +: NIB_W]),
        .b4 (b_r[idx*NIB_W +: NIB_W]),
        .bi (br),
        .d4 (diff4),
        .bo (br_next)
    );

    // Control FSM with registered outputs; one nibble retired per RUN cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_r    <= '0;
            b_r    <= '0;
            d_r    <= '0;
            idx    <= '0;
            br     <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            bout_r <= 1'b0;
`ifdef SUB_OVERFLOW_EN
            ovf_r  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE, DONE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        a_r    <= bus.a;
                        b_r    <= bus.b;
                        br     <= bus.bin;
                        d_r    <= '0;
                        idx    <= '0;
                        busy_r <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state  <= IDLE;
                    end
                end
                RUN: begin
                    d_r[idx*NIB_W +: NIB_W] <= diff4;
                    br <= br_next;
                    if (idx == LAST) begin
                        // Last slice: publish result; idx stays put until next accept
                        bout_r <= br_next;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                        state  <= DONE;
`ifdef SUB_OVERFLOW_EN
                        ovf_r  <= (a_r[W-1] != b_r[W-1]) & (diff4[NIB_W-1] != a_r[W-1]);
`endif
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.d    = d_r;
    assign bus.bout = bout_r;
`ifdef SUB_OVERFLOW_EN
    assign bus.ovf  = ovf_r;
`endif

endmodule

// File: tb/tb_lab3_serial_bls_sub.sv
// Scoreboard bench for lab3_serial_bls_sub: a driver pushes expected results
// from an arithmetic reference, a monitor pops and compares on every done.
module tb_lab3_serial_bls_sub;

    localparam int NB = 4;
    localparam int W  = 4 * NB;

    typedef struct {
        logic [W-1:0] d;
        logic         bout;
        logic         ovf;
        int           acc;
    } exp_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    int   cyc;
    exp_t q[$];

    lab3_serial_bls_sub_if #(.NIBBLES(NB)) bus ();

    lab3_serial_bls_sub #(.NIBBLES(NB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: plain unsigned arithmetic on whole operands
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        exp_t e;
        int unsigned ua, ub;
        ua     = a;
        ub     = b;
        e.d    = W'((ua + (1 << W) - ub - bin) % (1 << W));
        e.bout = (ua < ub + bin);
        e.ovf  = (a[W-1] != b[W-1]) && (e.d[W-1] != a[W-1]);
        e.acc  = 0;
        return e;
    endfunction

    // Wait for an idle/done slot, present operands, record expectation
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin, input bit hold);
        exp_t e;
        bit   ok;
        ok = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (!bus.busy) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("issue_wait_busy", 32'(bus.busy), 32'd0);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.bin   = bin;
        e         = model(a, b, bin);
        e.acc     = cyc + 1;
        q.push_back(e);
        if (!hold) begin
            @(negedge clk);
            bus.start = 1'b0;
        end
    endtask

    // Monitor: compare every done pulse against the head of the scoreboard
    initial begin
        exp_t e;
        bit   prev_done;
        prev_done = 0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (bus.done) begin
                    if (prev_done) chk("done_consecutive", 32'd1, 32'd0);
                    if (q.size() == 0) begin
                        chk("unexpected_done", 32'd1, 32'd0);
                    end else begin
                        e = q.pop_front();
                        chk("d", 32'(bus.d), 32'(e.d));
                        chk("bout", 32'(bus.bout), 32'(e.bout));
                        chk("latency", 32'(cyc - e.acc), 32'(NB));
                        chk("busy_at_done", 32'(bus.busy), 32'd0);
`ifdef SUB_OVERFLOW_EN
                        chk("ovf", 32'(bus.ovf), 32'(e.ovf));
`endif
                    end
                end
                prev_done = bus.done;
            end else begin
                prev_done = 0;
            end
        end
    end

    initial begin
        tests     = 0;
        fails     = 0;
        cyc       = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.bin   = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_d", 32'(bus.d), 32'd0);
        chk("rst_bout", 32'(bus.bout), 32'd0);
        rst_n = 1'b1;

        // Directed vectors
        issue(16'h1234, 16'h0234, 1'b0, 0);
        issue(16'h0000, 16'h0001, 1'b0, 0);
        issue(16'hFFFF, 16'hFFFF, 1'b1, 0);
        issue(16'h8000, 16'h0001, 1'b0, 0);
        issue(16'h0005, 16'h0003, 1'b0, 0);

        // Stray start during RUN with other operands must be ignored
        issue(16'h4321, 16'h1111, 1'b0, 0);
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = 16'hAAAA;
        bus.b     = 16'h5555;
        bus.bin   = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;

        // start held high through DONE: second op accepted at E5, done at E9
        issue(16'h7777, 16'h0123, 1'b1, 1);
        issue(16'h0100, 16'h0FFF, 1'b0, 0);

        // Asynchronous reset mid-run with a pending borrow
        issue(16'h0000, 16'h0001, 1'b0, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_d", 32'(bus.d), 32'd0);
        chk("midrst_bout", 32'(bus.bout), 32'd0);
`ifdef SUB_OVERFLOW_EN
        chk("midrst_ovf", 32'(bus.ovf), 32'd0);
`endif
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        issue(16'h5555, 16'h1111, 1'b0, 0);

        // Randomized operands, gaps and held starts
        for (int n = 0; n < 40; n++) begin
            bit h;
            h = (n != 39) && ($urandom_range(0, 3) == 0);
            issue(W'($urandom), W'($urandom), 1'($urandom), h);
            if (!h) repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Drain with a bounded wait
        for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
        chk("drain_empty", 32'(q.size()), 32'd0);
        repeat (10) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
